// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning the HI/LO registers.
//
// Accepts mult/multu/div/divu and mthi/mtlo from EX-stage control. Arithmetic
// results are formed combinationally from the latched operands. The countdown
// counter models the pipeline latency: the result is committed to HI/LO on the
// edge where the counter reaches zero. busy/hi/lo come straight from flops.
//
// Optional feature macro: MD_MADD_EN
//   defined   -> md_op 6 (MADD) / 7 (MADDU) accumulate A*B into {hi,lo}
//   undefined -> md_op 6/7 are ignored and no accumulator adder exists
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // ------------------------------------------------------------------
    // Operation encodings and FSM states
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MD_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Counter must hold the larger of the two latencies.
    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_count;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic             w_idle;
    logic             w_accept;
    logic             w_req_mul;
    logic             w_req_div;
    logic             w_launch;
    logic             w_mthi;
    logic             w_mtlo;
    logic [CNT_W-1:0] w_load;

    // Classify the incoming request; only IDLE accepts anything.
    // NOTE: every signal driven in an always_comb gets a default first so no
    // path through the case leaves it unassigned, which would infer a latch.
    always_comb begin
        w_req_mul = 1'b0;
        w_req_div = 1'b0;
        unique case (md_op)
            OP_MULT, OP_MULTU: w_req_mul = 1'b1;
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: w_req_mul = 1'b1;
`endif
            OP_DIV, OP_DIVU:   w_req_div = 1'b1;
            default: begin
                w_req_mul = 1'b0;
                w_req_div = 1'b0;
            end
        endcase
    end

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = start && w_idle;
    assign w_launch = w_accept && (w_req_mul || w_req_div);
    assign w_mthi   = w_accept && (md_op == OP_MTHI);
    assign w_mtlo   = w_accept && (md_op == OP_MTLO);
    assign w_load   = w_req_div ? DIV_LOAD : MULT_LOAD;

    // ------------------------------------------------------------------
    // Arithmetic on the latched operands
    // ------------------------------------------------------------------
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_op_div;
    logic        w_div_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_b_safe;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_zero;

    // Full 64-bit signed and unsigned products of the latched operands.
    always_comb begin
        w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_prod_u = {32'd0, r_a} * {32'd0, r_b};
    end

    // Sign-magnitude divider. Working on magnitudes makes the quotient
    // truncate toward zero and the remainder follow the dividend's sign.
    // 0x80000000 / -1 falls out naturally: magnitude quotient 0x80000000,
    // negated back to 0x80000000, remainder 0.
    always_comb begin
        w_op_div     = (r_op == OP_DIV) || (r_op == OP_DIVU);
        w_div_signed = (r_op == OP_DIV);
        w_a_neg      = w_div_signed && r_a[31];
        w_b_neg      = w_div_signed && r_b[31];
        w_a_mag      = w_a_neg ? (32'd0 - r_a) : r_a;
        w_b_mag      = w_b_neg ? (32'd0 - r_b) : r_b;
        w_div_zero   = (r_b == 32'd0);
        // Divisor forced non-zero so the divider never sees x/0; the result
        // is discarded in that case anyway.
        w_b_safe     = w_div_zero ? 32'd1 : w_b_mag;
        w_q_mag      = w_a_mag / w_b_safe;
        w_r_mag      = w_a_mag % w_b_safe;
        w_quot       = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
        w_rem        = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
    end

    // ------------------------------------------------------------------
    // Pending result select and commit qualification
    // ------------------------------------------------------------------
    logic [63:0] w_pending;
    logic        w_last;
    logic        w_commit;

    // Pick the 64-bit {hi,lo} value the in-flight op will commit.
    // For MADD/MADDU the base is the current HI/LO, which cannot change while
    // RUN is active, so it equals the value seen when start was accepted.
    always_comb begin
        w_pending = {r_hi, r_lo};
        unique case (r_op)
            OP_MULT:         w_pending = w_prod_s;
            OP_MULTU:        w_pending = w_prod_u;
            OP_DIV, OP_DIVU: w_pending = {w_rem, w_quot};
`ifdef MD_MADD_EN
            OP_MADD:         w_pending = {r_hi, r_lo} + w_prod_s;
            OP_MADDU:        w_pending = {r_hi, r_lo} + w_prod_u;
`endif
            default:         w_pending = {r_hi, r_lo};
        endcase
    end

    // Final edge of RUN: counter is about to reach zero.
    assign w_last   = (r_state == S_RUN) && (r_count == CNT_ONE);
    // Divide by zero burns the full latency but leaves HI/LO untouched.
    assign w_commit = w_last && !(w_op_div && w_div_zero);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // FSM and countdown: load on launch, decrement in RUN, leave on zero.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else if (r_state == S_RUN) begin
            r_count <= r_count - CNT_ONE;
            if (w_last) begin
                r_state <= S_IDLE;
            end
        end else if (w_launch) begin
            r_state <= S_RUN;
            r_count <= w_load;
        end
    end

    // Operand/op latch, captured only when an arithmetic op is launched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op <= OP_MULT;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_launch) begin
            r_op <= md_op;
            r_a  <= A;
            r_b  <= B;
        end
    end

    // HI/LO update: commit at end of RUN, or direct mthi/mtlo write in IDLE.
    // The two sources are mutually exclusive since commit happens only in RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (w_commit) begin
            r_hi <= w_pending[63:32];
            r_lo <= w_pending[31:0];
        end else if (w_mthi) begin
            r_hi <= A;
        end else if (w_mtlo) begin
            r_lo <= A;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, straight from flops
    // ------------------------------------------------------------------
    assign busy = r_state[0];
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
